cs_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one resource (bus, port or peripheral) among eight requesters and drives the one-hot active-low select lines through the team's existing `decoder_3_to_8` (active-low enable, active-low outputs). It arbitrates the request vector, holds a winner until release, and inserts a one-cycle turnaround gap. An optional watchdog forces release after a bounded hold. It sits between requesting masters and the chip-select fan-out of the shared datapath.

---
 rtl/cs_rr_scheduler_pkg.sv | 32 +++
 rtl/cs_rr_scheduler_if.sv | 25 ++
 rtl/cs_rr_scheduler_decoder.sv | 18 +
 rtl/cs_rr_scheduler.sv | 108 ++++++++++
 tb/tb_cs_rr_scheduler.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cs_rr_scheduler_pkg.sv
// Shared types and helpers for the chip-select round-robin scheduler.
// Optional watchdog is enabled with the macro CS_RR_SCHEDULER_WATCHDOG_EN
// (consumed by cs_rr_scheduler.sv).
package cs_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } cs_state_t;

  // First set request bit scanning upward from ptr, wrapping 7 -> 0.
  // Returns ptr when no request is set; callers only use it when |req.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cs_rr_scheduler_if.sv
// Request/select bundle between the requesting masters and the scheduler.
// Optional watchdog macro: CS_RR_SCHEDULER_WATCHDOG_EN (timeout stays 0 without it).
interface cs_rr_scheduler_if;
  import cs_sched_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] cs_n;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout;

  // Requester side: raises requests and releases, observes the grant.
  modport master (
    output req, done,
    input  cs_n, grant_id, busy, timeout
  );

  // Scheduler side.
  modport slave (
    input  req, done,
    output cs_n, grant_id, busy, timeout
  );

endinterface

// File: rtl/cs_rr_scheduler_decoder.sv
// decoder_3_to_8: active-low enable, active-low one-hot outputs.
// All outputs high while disabled. Unaffected by CS_RR_SCHEDULER_WATCHDOG_EN.
module decoder_3_to_8 (
  input  logic       en_n,
  input  logic [2:0] a,
  output logic [7:0] y_n
);

  // Drive exactly one low output for the selected index when enabled.
  always_comb begin
    // NOTE: default assigned first in combinational logic so no path infers a latch.
    y_n = 8'hFF;
    if (!en_n) begin
      y_n[a] = 1'b0;
    end
  end

endmodule

// File: rtl/cs_rr_scheduler.sv
// cs_rr_scheduler: round-robin arbiter for eight requesters with a one-cycle
// turnaround gap between grants, driving chip selects via decoder_3_to_8.
// Define CS_RR_SCHEDULER_WATCHDOG_EN to force release after HOLD_MAX grant cycles.
module cs_rr_scheduler
  import cs_sched_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  cs_rr_scheduler_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("cs_rr_scheduler: HOLD_MAX must be in 1..255");
  end

  cs_state_t          state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               wdog_expire;
  logic               dec_en_n;
  logic [NUM_REQ-1:0] cs_n;

`ifdef CS_RR_SCHEDULER_WATCHDOG_EN
  logic [7:0] wdog_cnt_q, wdog_cnt_d;
  logic       timeout_q, timeout_d;

  // Watchdog: count held cycles; zero outside GRANT so each grant starts fresh.
  always_comb begin
    wdog_cnt_d  = (state_q == GRANT) ? wdog_cnt_q + 8'd1 : 8'd0;
    wdog_expire = (state_q == GRANT) && (wdog_cnt_q == 8'(HOLD_MAX - 1));
    // A normal release on the same cycle wins, so no timeout pulse then.
    timeout_d   = wdog_expire && !bus.done && bus.req[grant_id_q];
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state, arbitration and pointer update.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE, GAP: begin
        if (|bus.req) begin
          grant_id_d = rr_pick(bus.req, ptr_q);
          ptr_d      = grant_id_d + 3'd1;
          state_d    = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release (done or dropped request) and watchdog both end in GAP;
        // new requests are only looked at from GAP.
        if (bus.done || !bus.req[grant_id_q] || wdog_expire) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, pointer and grant index registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is sampled only on the clock edge, so a
    // grant in flight drops straight to IDLE with no gap cycle.
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign dec_en_n = ~(state_q == GRANT);

  decoder_3_to_8 u_dec (
    .en_n (dec_en_n),
    .a    (grant_id_q),
    .y_n  (cs_n)
  );

  assign bus.cs_n     = cs_n;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = ~&cs_n;

endmodule

// File: tb/tb_cs_rr_scheduler.sv
// Self-checking bench for cs_rr_scheduler: table of directed vectors plus
// hand-written multi-cycle sequences (idle, FF sweep, watchdog, reset mid-grant).
// Builds with or without CS_RR_SCHEDULER_WATCHDOG_EN.
module tb_cs_rr_scheduler;

  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst_n;

  cs_rr_scheduler_if bus ();

  cs_rr_scheduler #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] cs_n;
    logic [2:0] gid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] c, input logic [2:0] g, input logic t);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d; v.cs_n = c; v.gid = g; v.tmo = t;
    vecs.push_back(v);
  endfunction

  // Drive inputs, let one rising edge sample them, then look at outputs.
  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst_n    = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic [2:0] g,
                            input logic t);
    check({tag, " cs_n"}, 32'(bus.cs_n), 32'(c));
    check({tag, " busy"}, 32'(bus.busy), 32'(c != 8'hFF));
    check({tag, " grant_id"}, 32'(bus.grant_id), 32'(g));
    check({tag, " timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Single request 8'h04, done on the third grant cycle.
    add(1, 8'h04, 0, 8'hFB, 3'd2, 0);
    add(1, 8'h04, 0, 8'hFB, 3'd2, 0);
    add(1, 8'h04, 0, 8'hFB, 3'd2, 0);
    add(1, 8'h04, 1, 8'hFF, 3'd2, 0);
    add(1, 8'h00, 0, 8'hFF, 3'd2, 0);
    // Reset, then 8'h81 with done every grant: 0,7,0,7 with ptr wrapping.
    add(0, 8'h00, 0, 8'hFF, 3'd0, 0);
    add(1, 8'h81, 0, 8'hFE, 3'd0, 0);
    add(1, 8'h81, 1, 8'hFF, 3'd0, 0);
    add(1, 8'h81, 0, 8'h7F, 3'd7, 0);
    add(1, 8'h81, 1, 8'hFF, 3'd7, 0);
    add(1, 8'h81, 0, 8'hFE, 3'd0, 0);
    add(1, 8'h81, 1, 8'hFF, 3'd0, 0);
    add(1, 8'h81, 0, 8'h7F, 3'd7, 0);
    add(1, 8'h00, 1, 8'hFF, 3'd7, 0);
    add(1, 8'h00, 0, 8'hFF, 3'd7, 0);
    // Holder drops its request -> released, then re-arbitrates behind bit 1.
    add(1, 8'h03, 0, 8'hFE, 3'd0, 0);
    add(1, 8'h02, 0, 8'hFF, 3'd0, 0);
    add(1, 8'h03, 0, 8'hFD, 3'd1, 0);
    add(1, 8'h03, 1, 8'hFF, 3'd1, 0);
    add(1, 8'h03, 0, 8'hFE, 3'd0, 0);
    add(1, 8'h00, 0, 8'hFF, 3'd0, 0);
    add(1, 8'h00, 0, 8'hFF, 3'd0, 0);

    // Reset state.
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    expect_out("reset", 8'hFF, 3'd0, 1'b0);

    // No requests for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'h00, 0);
      check($sformatf("idle%0d cs_n", i), 32'(bus.cs_n), 32'h000000FF);
      check($sformatf("idle%0d busy", i), 32'(bus.busy), 32'd0);
    end

    // Table-driven vectors.
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].cs_n, vecs[i].gid, vecs[i].tmo);
    end

    // All requesting, done each grant: ids 0..7 then 0 again.
    step(0, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_cs;
      exp_cs = ~(8'h01 << (k % 8));
      step(1, 8'hFF, 0);
      expect_out($sformatf("ff%0d", k), exp_cs, 3'(k % 8), 1'b0);
      check($sformatf("ff%0d onehot", k), 32'($countones(~bus.cs_n)), 32'd1);
      step(1, 8'hFF, 1);
      expect_out($sformatf("ff%0d gap", k), 8'hFF, 3'(k % 8), 1'b0);
    end
    step(1, 8'h00, 0);
    step(1, 8'h00, 0);

    // Watchdog: 8'h0A held, no done.
    step(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h0A, 0);
      expect_out($sformatf("wd hold%0d", i), 8'hFD, 3'd1, 1'b0);
    end
`ifdef CS_RR_SCHEDULER_WATCHDOG_EN
    step(1, 8'h0A, 0);
    expect_out("wd gap", 8'hFF, 3'd1, 1'b1);
    step(1, 8'h0A, 0);
    expect_out("wd next", 8'hF7, 3'd3, 1'b0);
`else
    for (int i = 4; i < 16; i++) begin
      step(1, 8'h0A, 0);
      expect_out($sformatf("wd hold%0d", i), 8'hFD, 3'd1, 1'b0);
    end
`endif
    step(1, 8'h00, 1);
    step(1, 8'h00, 0);

    // Reset during grant of id 5, then ptr must restart at 0.
    step(0, 8'h00, 0);
    step(1, 8'h20, 0);
    expect_out("rst g5", 8'hDF, 3'd5, 1'b0);
    step(1, 8'h20, 0);
    expect_out("rst g5 hold", 8'hDF, 3'd5, 1'b0);
    step(0, 8'h20, 0);
    expect_out("rst mid", 8'hFF, 3'd0, 1'b0);
    step(1, 8'h41, 0);
    expect_out("rst ptr0", 8'hFE, 3'd0, 1'b0);
    step(1, 8'h41, 1);
    expect_out("rst rel", 8'hFF, 3'd0, 1'b0);
    step(1, 8'h20, 0);
    expect_out("rst g5 again", 8'hDF, 3'd5, 1'b0);
    step(1, 8'h20, 1);
    expect_out("rst g5 rel", 8'hFF, 3'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
